if_fetch_stage: RTL



---
 rtl/if_fetch_stage.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RV64 instruction-fetch stage feeding decode.
// Issues in-order word requests to instruction memory under a credit limit,
// buffers returned words in a small prefetch FIFO, and presents a registered
// {inst, pc, inst_valid} triple to decode. A redirect flushes the FIFO and
// discards any wrong-path responses still in flight.
// Optional build macro: IF_PERF_CNT_EN adds perf_fetch_cnt / perf_bubble_cnt.
`timescale 1ns/1ps
module if_fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   input  logic        stall,
   output logic [31:0] inst,
   output logic [63:0] pc,
   output logic        inst_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_bubble_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(DEPTH);

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // Architectural state
   logic [63:0]      fetch_pc_q, fetch_pc_d;
   logic [63:0]      resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      inst_q, inst_d;
   logic [63:0]      pc_q, pc_d;
   logic             valid_q, valid_d;
   fetch_entry_t     fifo_q [DEPTH];

   // Per-cycle control
   logic [CNT_W:0] in_use;
   logic           credit_ok;
   logic           grant;
   logic           resp;
   logic           drop_resp;
   logic           keep_resp;
   logic           push;
   logic           pop;
   logic           load_valid;
   logic           load_bubble;
   logic [63:0]    redirect_base;
   fetch_entry_t   head;

   assign in_use        = {1'b0, outstanding_q} + {1'b0, count_q};
   assign credit_ok     = (in_use < DEPTH_W);
   assign imem_req      = !rst && !redirect_valid && credit_ok;
   assign imem_addr     = fetch_pc_q;
   assign grant         = imem_req && imem_gnt;
   // A response with nothing outstanding is a protocol error and is ignored.
   assign resp          = imem_rvalid && (outstanding_q != '0);
   assign drop_resp     = resp && (drop_cnt_q != '0);
   assign keep_resp     = resp && (drop_cnt_q == '0) && !redirect_valid;
   assign redirect_base = redirect_pc & ~64'h3;
   assign head          = fifo_q[rd_ptr_q];

   assign inst       = inst_q;
   assign pc         = pc_q;
   assign inst_valid = valid_q;

   // Next-state for credits, fetch/response PCs, FIFO pointers and output register.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // a variable unassigned, which would otherwise infer a latch.
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(resp);
      drop_cnt_d    = drop_cnt_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      inst_d        = inst_q;
      pc_d          = pc_q;
      valid_d       = valid_q;
      push          = 1'b0;
      pop           = 1'b0;
      load_valid    = 1'b0;
      load_bubble   = 1'b0;

      if (redirect_valid) begin
         // Everything still in flight is wrong-path, including any response
         // arriving right now.
         fetch_pc_d  = redirect_base;
         resp_pc_d   = redirect_base;
         drop_cnt_d  = outstanding_q - CNT_W'(resp);
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         count_d     = '0;
         inst_d      = NOP_INST;
         valid_d     = 1'b0;
         load_bubble = 1'b1;
      end else begin
         if (grant)     fetch_pc_d = fetch_pc_q + 64'd4;
         if (drop_resp) drop_cnt_d = drop_cnt_q - CNT_W'(1);
         if (keep_resp) resp_pc_d  = resp_pc_q + 64'd4;

         if (!stall) begin
            if (count_q != '0) begin
               pop        = 1'b1;
               push       = keep_resp;
               inst_d     = head.inst;
               pc_d       = head.pc;
               valid_d    = 1'b1;
               load_valid = 1'b1;
            end else if (keep_resp) begin
               // Empty FIFO: a kept response goes straight to the output.
               inst_d     = imem_rdata;
               pc_d       = resp_pc_q;
               valid_d    = 1'b1;
               load_valid = 1'b1;
            end else begin
               inst_d      = NOP_INST;
               valid_d     = 1'b0;
               load_bubble = 1'b1;
            end
         end else begin
            push = keep_resp;
         end

         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         inst_q        <= NOP_INST;
         pc_q          <= '0;
         valid_q       <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         inst_q        <= inst_d;
         pc_q          <= pc_d;
         valid_q       <= valid_d;
      end
   end

   // Prefetch FIFO storage write.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is not reset; count_q/pointers define which
      // entries are meaningful, so stale contents are never observed.
      if (!rst && push) fifo_q[wr_ptr_q] <= '{pc: resp_pc_q, inst: imem_rdata};
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_q;
   logic [31:0] perf_bubble_q;

   // Count valid loads and bubble loads into the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_q  <= '0;
         perf_bubble_q <= '0;
      end else begin
         if (load_valid)  perf_fetch_q  <= perf_fetch_q + 32'd1;
         if (load_bubble) perf_bubble_q <= perf_bubble_q + 32'd1;
      end
   end

   assign perf_fetch_cnt  = perf_fetch_q;
   assign perf_bubble_cnt = perf_bubble_q;
`else
   logic perf_unused;
   assign perf_unused = load_valid ^ load_bubble;
`endif

`ifndef SYNTHESIS
   // A response must always correspond to a granted, unanswered request.
   a_rvalid_has_outstanding : assert property (
      @(posedge clk) disable iff (rst) imem_rvalid |-> (outstanding_q != '0)
   ) else $error("imem_rvalid with no outstanding request");
`endif

endmodule
